// File: rtl/watch_time_set_if.sv
// Button, running-time and edited-time signals between the watch setter and its neighbours.
// Master drives buttons and running time; slave returns edited time, load strobe and blink mask.
interface watch_time_set_if;
   logic       BTN_MODE;
   logic       BTN_INC;
   logic [3:0] CUR_H1;
   logic [3:0] CUR_H0;
   logic [3:0] CUR_M1;
   logic [3:0] CUR_M0;
   logic [3:0] SET_H1;
   logic [3:0] SET_H0;
   logic [3:0] SET_M1;
   logic [3:0] SET_M0;
   logic [3:0] SET_S1;
   logic [3:0] SET_S0;
   logic       LOAD;
   logic       SETTING;
   logic       BLINK_H;
   logic       BLINK_M;

   modport master (
      output BTN_MODE, BTN_INC, CUR_H1, CUR_H0, CUR_M1, CUR_M0,
      input  SET_H1, SET_H0, SET_M1, SET_M0, SET_S1, SET_S0,
      input  LOAD, SETTING, BLINK_H, BLINK_M
   );

   modport slave (
      input  BTN_MODE, BTN_INC, CUR_H1, CUR_H0, CUR_M1, CUR_M0,
      output SET_H1, SET_H0, SET_M1, SET_M0, SET_S1, SET_S0,
      output LOAD, SETTING, BLINK_H, BLINK_M
   );
endinterface

// File: rtl/watch_time_set.sv
// Watch time setter: debounced MODE/INC buttons step HH then MM in BCD, commit with a one-cycle LOAD.
// Press acts 3+DEB_CYCLES edges after the raw rise; no backpressure, presses outside valid states are dropped.
module watch_time_set #(
   parameter logic [15:0] DEB_CYCLES     = 16'd50000,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000,
   parameter logic [23:0] BLINK_CYCLES   = 24'd2500000
) (
   input logic             CLK_IN,
   input logic             RST,
   watch_time_set_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SET_H, SET_M, COMMIT} state_t;

   // Index 0 is MODE, index 1 is INC.
   logic [1:0]  sync_a;
   logic [1:0]  sync_b;
   logic [1:0]  deb_lvl;
   logic [1:0]  press;
   logic [15:0] deb_cnt [2];

   always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
         sync_a     <= '0;
         sync_b     <= '0;
         deb_lvl    <= '0;
         press      <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync_a <= {bus.BTN_INC, bus.BTN_MODE};
         sync_b <= sync_a;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_CYCLES - 16'd1) begin
               deb_cnt[i] <= '0;
               deb_lvl[i] <= sync_b[i];
               press[i]   <= sync_b[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 16'd1;
            end
         end
      end
   end

   logic mode_p;
   logic inc_p;
   assign mode_p = press[0];
   assign inc_p  = press[1];

   state_t      state;
   logic [3:0]  h1, h0, m1, m0;
   logic        load, setting, blink_h, blink_m, toggle;
   logic [31:0] tmo_cnt;
   logic [23:0] blink_cnt;

   logic cap_h_ok;
   logic cap_m_ok;
   assign cap_h_ok = ((bus.CUR_H1 < 4'd2) && (bus.CUR_H0 <= 4'd9)) ||
                     ((bus.CUR_H1 == 4'd2) && (bus.CUR_H0 <= 4'd3));
   assign cap_m_ok = (bus.CUR_M1 <= 4'd5) && (bus.CUR_M0 <= 4'd9);

   logic [3:0] h1_inc, h0_inc, m1_inc, m0_inc;

   always_comb begin
      h1_inc = h1;
      h0_inc = h0 + 4'd1;
      if (h1 == 4'd2 && h0 == 4'd3) begin
         h1_inc = 4'd0;
         h0_inc = 4'd0;
      end else if (h0 == 4'd9) begin
         h1_inc = h1 + 4'd1;
         h0_inc = 4'd0;
      end
      m1_inc = m1;
      m0_inc = m0 + 4'd1;
      if (m0 == 4'd9) begin
         m0_inc = 4'd0;
         m1_inc = (m1 == 4'd5) ? 4'd0 : m1 + 4'd1;
      end
   end

   // Later non-blocking writes in a branch override the free-running blink/timeout step.
   always_ff @(posedge CLK_IN or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         h1        <= '0;
         h0        <= '0;
         m1        <= '0;
         m0        <= '0;
         load      <= 1'b0;
         setting   <= 1'b0;
         blink_h   <= 1'b0;
         blink_m   <= 1'b0;
         toggle    <= 1'b0;
         tmo_cnt   <= '0;
         blink_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               load <= 1'b0;
               if (mode_p) begin
                  h1        <= cap_h_ok ? bus.CUR_H1 : 4'd0;
                  h0        <= cap_h_ok ? bus.CUR_H0 : 4'd0;
                  m1        <= cap_m_ok ? bus.CUR_M1 : 4'd0;
                  m0        <= cap_m_ok ? bus.CUR_M0 : 4'd0;
                  state     <= SET_H;
                  setting   <= 1'b1;
                  tmo_cnt   <= '0;
                  blink_cnt <= '0;
                  toggle    <= 1'b0;
                  blink_h   <= 1'b0;
                  blink_m   <= 1'b0;
               end
            end
            SET_H, SET_M: begin
               tmo_cnt <= tmo_cnt + 32'd1;
               if (blink_cnt == BLINK_CYCLES - 24'd1) begin
                  blink_cnt <= '0;
                  toggle    <= ~toggle;
                  blink_h   <= ~toggle & (state == SET_H);
                  blink_m   <= ~toggle & (state == SET_M);
               end else begin
                  blink_cnt <= blink_cnt + 24'd1;
               end

               if (mode_p || inc_p) begin
                  tmo_cnt   <= '0;
                  blink_cnt <= '0;
                  toggle    <= 1'b0;
                  blink_h   <= 1'b0;
                  blink_m   <= 1'b0;
                  if (mode_p && state == SET_H) begin
                     state <= SET_M;
                  end else if (mode_p) begin
                     state   <= COMMIT;
                     setting <= 1'b0;
                     load    <= 1'b1;
                  end else if (state == SET_H) begin
                     h1 <= h1_inc;
                     h0 <= h0_inc;
                  end else begin
                     m1 <= m1_inc;
                     m0 <= m0_inc;
                  end
               end else if (tmo_cnt == TIMEOUT_CYCLES - 32'd1) begin
                  state     <= IDLE;
                  setting   <= 1'b0;
                  tmo_cnt   <= '0;
                  blink_cnt <= '0;
                  toggle    <= 1'b0;
                  blink_h   <= 1'b0;
                  blink_m   <= 1'b0;
               end
            end
            default: begin
               load  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.SET_H1  = h1;
   assign bus.SET_H0  = h0;
   assign bus.SET_M1  = m1;
   assign bus.SET_M0  = m0;
   assign bus.SET_S1  = 4'd0;
   assign bus.SET_S0  = 4'd0;
   assign bus.LOAD    = load;
   assign bus.SETTING = setting;
   assign bus.BLINK_H = blink_h;
   assign bus.BLINK_M = blink_m;

endmodule

// File: tb/tb_watch_time_set.sv
// Bench for watch_time_set: directed scenarios plus random button sequences against a time-value model.
module tb_watch_time_set;

   logic CLK_IN = 1'b0;
   logic RST    = 1'b0;
   always #5 CLK_IN = ~CLK_IN;

   watch_time_set_if wif ();

   watch_time_set #(
      .DEB_CYCLES    (16'd4),
      .TIMEOUT_CYCLES(32'd200),
      .BLINK_CYCLES  (24'd8)
   ) dut (
      .CLK_IN(CLK_IN),
      .RST   (RST),
      .bus   (wif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: mode 0 idle, 1 editing hours, 2 editing minutes; time kept as plain integers.
   int          m_mode = 0;
   int          m_hour = 0;
   int          m_min  = 0;
   int          exp_loads = 0;
   logic [15:0] exp_ld_val = '0;

   int          load_cnt = 0;
   int          load_wide = 0;
   int          load_setting = 0;
   logic        load_prev = 1'b0;
   logic [15:0] ld_val = '0;

   function automatic logic [15:0] to_bcd(input int h, input int m);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   always @(negedge CLK_IN) begin
      if (wif.LOAD) begin
         load_cnt++;
         ld_val = {wif.SET_H1, wif.SET_H0, wif.SET_M1, wif.SET_M0};
         if (wif.SETTING) load_setting++;
         if (load_prev) load_wide++;
      end
      load_prev = wif.LOAD;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK_IN);
   endtask

   task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
      wif.CUR_H1 = a;
      wif.CUR_H0 = b;
      wif.CUR_M1 = c;
      wif.CUR_M0 = d;
   endtask

   task automatic model_press(input bit mode, input bit inc);
      int ch, cm;
      if (mode) begin
         case (m_mode)
            0: begin
               ch = int'(wif.CUR_H1) * 10 + int'(wif.CUR_H0);
               cm = int'(wif.CUR_M1) * 10 + int'(wif.CUR_M0);
               m_hour = (wif.CUR_H0 < 10 && ch < 24) ? ch : 0;
               m_min  = (wif.CUR_M0 < 10 && cm < 60) ? cm : 0;
               m_mode = 1;
            end
            1: m_mode = 2;
            default: begin
               exp_loads++;
               exp_ld_val = to_bcd(m_hour, m_min);
               m_mode = 0;
            end
         endcase
      end else if (inc) begin
         if (m_mode == 1) m_hour = (m_hour + 1) % 24;
         else if (m_mode == 2) m_min = (m_min + 1) % 60;
      end
   endtask

   task automatic press(input bit mode, input bit inc, input int hold);
      @(negedge CLK_IN);
      wif.BTN_MODE = mode;
      wif.BTN_INC  = inc;
      tick(hold);
      wif.BTN_MODE = 1'b0;
      wif.BTN_INC  = 1'b0;
      tick(10);
      model_press(mode, inc);
   endtask

   task automatic checkpoint(input string tag);
      check_eq({tag, "_set"}, {16'd0, wif.SET_H1, wif.SET_H0, wif.SET_M1, wif.SET_M0},
               {16'd0, to_bcd(m_hour, m_min)});
      check_eq({tag, "_setting"}, {31'd0, wif.SETTING}, {31'd0, (m_mode != 0)});
      check_eq({tag, "_loads"}, load_cnt, exp_loads);
      check_eq({tag, "_ldval"}, {16'd0, ld_val}, {16'd0, exp_ld_val});
      check_eq({tag, "_blinkh"}, {31'd0, wif.BLINK_H & (m_mode != 1)}, 32'd0);
      check_eq({tag, "_blinkm"}, {31'd0, wif.BLINK_M & (m_mode != 2)}, 32'd0);
   endtask

   initial begin
      bit seen_h0, seen_h1, seen_m;
      int r, hh, mm;

      wif.BTN_MODE = 1'b0;
      wif.BTN_INC  = 1'b0;
      set_cur(4'd0, 4'd0, 4'd0, 4'd0);
      tick(3);
      RST = 1'b1;
      tick(50);
      checkpoint("idle");
      check_eq("sec_zero", {24'd0, wif.SET_S1, wif.SET_S0}, 32'd0);

      // 12:34 -> 15:36
      set_cur(4'd1, 4'd2, 4'd3, 4'd4);
      press(1, 0, 6); checkpoint("a_mode1");
      repeat (3) begin press(0, 1, 6); checkpoint("a_inch"); end
      press(1, 0, 6); checkpoint("a_mode2");
      repeat (2) begin press(0, 1, 6); checkpoint("a_incm"); end
      press(1, 0, 6); checkpoint("a_commit");
      check_eq("a_value", {16'd0, ld_val}, {16'd0, 16'h1536});

      // 23:59 wraps to 00:00
      set_cur(4'd2, 4'd3, 4'd5, 4'd9);
      press(1, 0, 6); press(0, 1, 6); press(1, 0, 6); press(0, 1, 6); press(1, 0, 6);
      checkpoint("b_commit");
      check_eq("b_value", {16'd0, ld_val}, 32'd0);

      // Short glitches in SET_H, then a minimum-length press
      set_cur(4'd0, 4'd7, 4'd1, 4'd0);
      press(1, 0, 6);
      repeat (5) begin
         @(negedge CLK_IN); wif.BTN_INC = 1'b1;
         tick(3);           wif.BTN_INC = 1'b0;
         tick(6);
      end
      checkpoint("c_glitch");
      press(0, 1, 4); checkpoint("c_inc4");
      seen_h0 = 0; seen_h1 = 0; seen_m = 0;
      repeat (40) begin
         @(negedge CLK_IN);
         if (wif.BLINK_H) seen_h1 = 1; else seen_h0 = 1;
         if (wif.BLINK_M) seen_m = 1;
      end
      check_eq("c_blink_on", {31'd0, seen_h1}, 32'd1);
      check_eq("c_blink_off", {31'd0, seen_h0}, 32'd1);
      check_eq("c_blink_m", {31'd0, seen_m}, 32'd0);

      // Timeout out of SET_M
      press(1, 0, 6); checkpoint("d_setm");
      tick(230);
      m_mode = 0;
      checkpoint("d_timeout");

      // Reset in the middle of SET_H
      set_cur(4'd1, 4'd9, 4'd4, 4'd5);
      press(1, 0, 6); checkpoint("e_seth");
      @(negedge CLK_IN);
      RST = 1'b0;
      #1;
      m_mode = 0; m_hour = 0; m_min = 0;
      checkpoint("e_reset");
      check_eq("e_load", {31'd0, wif.LOAD}, 32'd0);
      tick(2);
      RST = 1'b1;
      tick(5);
      checkpoint("e_after");

      // Invalid capture, MODE wins over a simultaneous INC
      set_cur(4'hA, 4'hF, 4'hA, 4'hF);
      press(1, 0, 6); checkpoint("f_cap");
      press(1, 1, 6); checkpoint("f_both");
      press(1, 0, 6); checkpoint("f_commit");
      check_eq("f_value", {16'd0, ld_val}, 32'd0);

      // Random sequences
      for (int it = 0; it < 60; it++) begin
         if (m_mode == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               hh = $urandom_range(0, 23);
               mm = $urandom_range(0, 59);
               set_cur(4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10));
            end else begin
               set_cur(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
         end
         r = $urandom_range(0, 9);
         if (r < 3)       press(1, 0, $urandom_range(4, 25));
         else if (r < 8)  press(0, 1, $urandom_range(4, 25));
         else if (r == 8) press(1, 1, $urandom_range(4, 25));
         else             tick($urandom_range(0, 30));
         checkpoint("rnd");
      end

      check_eq("load_width", load_wide, 0);
      check_eq("load_setting", load_setting, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/watch_time_set.md
# watch_time_set

Time-setting controller for the watch: the input-side counterpart to the BCD counter chain and display mux. It debounces two push buttons, captures the running time, and lets the user step hours and then minutes in BCD. On commit it presents the new HH:MM:00 to the counter chain with a single-cycle load strobe. It also drives a blink mask so the display mux can flash the field being edited.

## Interface
Parameters:
- DEB_CYCLES, 16'd50000: clock cycles a synchronised button level must stay stable before it is accepted (1..65535).
- TIMEOUT_CYCLES, 32'd500000000: cycles with no accepted press before an edit is abandoned (≥1).
- BLINK_CYCLES, 24'd2500000: half-period of the blink toggle (≥1).

Ports:
- CLK_IN input 1: system clock, rising edge.
- RST input 1: asynchronous reset, active-low.
- BTN_MODE input 1: raw mode button, active-high, asynchronous to CLK_IN.
- BTN_INC input 1: raw increment button, active-high, asynchronous to CLK_IN.
- CUR_H1, CUR_H0, CUR_M1, CUR_M0 input 4 each: running time from the counter chain, BCD.
- SET_H1, SET_H0, SET_M1, SET_M0 output 4 each: edited time, BCD, registered.
- SET_S1, SET_S0 output 4 each: constant 4'd0.
- LOAD output 1: one-cycle strobe; counters take SET_* on this edge.
- SETTING output 1: high while in SET_H or SET_M.
- BLINK_H, BLINK_M output 1 each: blank request for the hour and minute digits.

## Operation
- Button path: each button goes through a 2-flop synchroniser, then a per-button stability counter.
  - The debounced level changes only after DEB_CYCLES consecutive cycles of the new synchronised level.
  - A press event is a 0→1 change of the debounced level, one cycle wide. Releases generate no event.
- State machine states: IDLE, SET_H, SET_M, COMMIT.
  - IDLE + MODE press → SET_H. On that edge, capture CUR_* into SET_*.
  - If the captured hour is not valid BCD 00..23, force it to 00. If the captured minute is not valid BCD 00..59, force it to 00.
  - SET_H + INC press: hour += 1 in BCD, wrapping 23→00. Rules: if 23 → 00; else if H0 = 9 → H0 = 0, H1 + 1; else H0 + 1.
  - SET_H + MODE press → SET_M.
  - SET_M + INC press: minute += 1 in BCD, wrapping 59→00. Rules: if M0 = 9 → M0 = 0 and M1 = (M1 = 5 ? 0 : M1 + 1); else M0 + 1. Hour is unaffected.
  - SET_M + MODE press → COMMIT.
  - COMMIT: LOAD = 1 for exactly one cycle, then unconditional → IDLE.
  - SET_H or SET_M with TIMEOUT_CYCLES elapsed since entry or the last accepted press → IDLE, no LOAD; SET_* hold their values.
- Simultaneous MODE and INC presses in the same cycle: MODE wins and INC is discarded.
- In IDLE, INC presses are ignored.
- Presses arriving during COMMIT are discarded.
- Blink: a toggle counter runs only while SETTING = 1.
  - BLINK_H = toggle & (state == SET_H); BLINK_M = toggle & (state == SET_M).
  - The toggle restarts at 0 on every state entry and on every accepted INC, so the edited digit shows immediately.
- Reset (RST = 0, at any time including mid-edit): state IDLE, all counters and synchronisers 0, SET_* = 0, LOAD = 0, SETTING = 0, BLINK_H = BLINK_M = 0. No LOAD is produced because of reset.

## Timing
- Synchroniser latency: 2 cycles.
- Debounce: a raw rise held steadily yields the press event on clock edge 2 + DEB_CYCLES after the first sampling edge that sees it. The resulting state/SET_* update is visible one cycle later.
- LOAD is asserted on the cycle after the SET_M MODE press is registered and is deasserted on the next cycle.
  - SET_* are stable from one cycle before LOAD until the next capture.
- SETTING falls in the same cycle LOAD rises (COMMIT is not a setting state).
- Timeout is checked every cycle. Exit happens on the edge where the counter reaches TIMEOUT_CYCLES − 1.
  - A press on that same edge wins: the press is taken and the timeout counter is cleared.
- Bounces shorter than DEB_CYCLES produce no events.
- Max event rate: one press per button per 2·DEB_CYCLES cycles.

## Test plan
- Bench parameters: DEB_CYCLES = 4, TIMEOUT_CYCLES = 200, BLINK_CYCLES = 8.
- Reset, then idle 50 cycles → all outputs 0, LOAD never high.
- CUR = 12:34; MODE, INC×3, MODE, INC×2, MODE → SETTING high between presses; exactly one LOAD pulse with SET = 15:36:00.
- CUR = 23:59; MODE, INC, MODE, INC, MODE → LOAD with SET = 00:00:00 (both wraps exercised).
- BTN_INC glitches of 3 cycles high ×5 while in SET_H → SET_H* unchanged; a 4-cycle-stable press then increments exactly once.
- Enter SET_M, then no presses for 200 cycles → return to IDLE, SETTING = 0, no LOAD. Assert RST mid-SET_H on another run → immediate IDLE with SET_* = 0.
- CUR = 4'hA:4'hF (invalid); MODE, then MODE and INC pressed in the same cycle, then MODE → INC ignored; LOAD with SET = 00:00:00.
